// File: rtl/interlayer_addcp.sv
// -----------------------------------------------------------------------------
// interlayer_addcp
// Transmit-side cyclic-prefix inserter. One OFDM symbol of N_FFT complex
// samples is collected into one of two ping-pong banks; once a bank is full the
// reader emits its last N_CP samples followed by the whole symbol, one sample
// per iena strobe, with a single cycle of read latency.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   isop, ival         input start-of-symbol / sample valid
//   in_real_data       input I sample
//   in_imag_data       input Q sample
//   ordy               write bank can accept samples
//   iena               output sample request strobe
//   osop, oval, oeop   output first-CP / valid / last-body markers
//   out_real_data      output I sample
//   out_imag_data      output Q sample
//   count_frame        completed output symbols, wraps at 128
//   ounderrun          request seen while idle with no full bank
// -----------------------------------------------------------------------------
module interlayer_addcp #(
    parameter int DATA_W = 12,
    parameter int N_FFT  = 1024,
    parameter int N_CP   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isop,
    input  logic              ival,
    input  logic [DATA_W-1:0] in_real_data,
    input  logic [DATA_W-1:0] in_imag_data,
    output logic              ordy,
    input  logic              iena,
    output logic              osop,
    output logic              oval,
    output logic              oeop,
    output logic [DATA_W-1:0] out_real_data,
    output logic [DATA_W-1:0] out_imag_data,
    output logic [6:0]        count_frame,
    output logic              ounderrun
);

    localparam int AW = $clog2(N_FFT);
    localparam logic [AW-1:0] CP_START = AW'(N_FFT - N_CP);
    localparam logic [AW-1:0] LAST     = AW'(N_FFT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_full;
    logic                r_wr_bank, r_rd_bank;
    logic [AW-1:0]       r_wr_idx, r_rd_ptr;
    logic [2*DATA_W-1:0] r_mem [0:2*N_FFT-1];
    logic [2*DATA_W-1:0] r_rd_data;
    logic                r_oval, r_osop, r_oeop, r_urun;
    logic [6:0]          r_count;

    logic                w_accept, w_wr_en, w_wr_done;
    logic [AW-1:0]       w_wr_addr;
    logic [1:0]          w_set, w_clr;
    logic                w_rd_full;
    logic                w_issue, w_sop, w_rd_last, w_urun;
    logic [AW-1:0]       w_rd_addr;

    // ------------------------------------------------------------------ write
    assign ordy      = ~r_full[r_wr_bank];
    assign w_accept  = ival & ordy;
    // Samples without isop are only stored inside an open symbol (index != 0)
    assign w_wr_en   = w_accept & (isop | (r_wr_idx != '0));
    assign w_wr_addr = isop ? '0 : r_wr_idx;
    assign w_wr_done = w_wr_en & ~isop & (r_wr_idx == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_en) begin
            if (w_wr_done) begin
                r_wr_idx  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_idx  <= w_wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[{r_wr_bank, w_wr_addr}] <= {in_real_data, in_imag_data};
    end

    // The writer never targets the bank the reader is draining, so set and
    // clear on the same bank cannot coincide.
    assign w_set = w_wr_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_full <= '0;
        else     r_full <= (r_full | w_set) & ~w_clr;
    end

    // ------------------------------------------------------------------- read
    assign w_rd_full = r_full[r_rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (iena && w_rd_full)
                        w_state_nxt = (CP_START == LAST) ? S_BODY : S_CP;
            S_CP:   if (iena && r_rd_ptr == LAST) w_state_nxt = S_BODY;
            S_BODY: if (iena && r_rd_ptr == LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = 1'b0;
        w_sop     = 1'b0;
        w_rd_last = 1'b0;
        w_urun    = 1'b0;
        w_rd_addr = r_rd_ptr;
        case (r_state)
            S_IDLE: begin
                w_rd_addr = CP_START;
                if (iena) begin
                    w_issue = w_rd_full;
                    w_sop   = w_rd_full;
                    w_urun  = ~w_rd_full;
                end
            end
            S_CP:   w_issue = iena;
            S_BODY: begin
                w_issue   = iena;
                w_rd_last = iena & (r_rd_ptr == LAST);
            end
            default: ;
        endcase
    end

    // Address wrap from N_FFT-1 to 0 at the CP/body boundary is the natural
    // power-of-two rollover of the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_issue)   r_rd_ptr  <= w_rd_addr + 1'b1;
            if (w_rd_last) r_rd_bank <= ~r_rd_bank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
            r_oval    <= 1'b0;
            r_osop    <= 1'b0;
            r_oeop    <= 1'b0;
            r_urun    <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_issue) r_rd_data <= r_mem[{r_rd_bank, w_rd_addr}];
            r_oval <= w_issue;
            r_osop <= w_sop;
            r_oeop <= w_rd_last;
            r_urun <= w_urun;
            if (w_rd_last) r_count <= r_count + 7'd1;
        end
    end

    assign oval          = r_oval;
    assign osop          = r_osop;
    assign oeop          = r_oeop;
    assign ounderrun     = r_urun;
    assign count_frame   = r_count;
    assign out_real_data = r_rd_data[2*DATA_W-1:DATA_W];
    assign out_imag_data = r_rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_interlayer_addcp.sv
// -----------------------------------------------------------------------------
// tb_interlayer_addcp
// Scoreboard bench for interlayer_addcp with a reduced symbol size. A symbol
// level reference model predicts acceptance, buffered-symbol count, read
// requests and the expected output sequence; a monitor compares on each cycle.
// -----------------------------------------------------------------------------
module tb_interlayer_addcp;

    localparam int DW  = 12;
    localparam int NF  = 64;
    localparam int NC  = 8;
    localparam int LEN = NF + NC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          isop = 1'b0, ival = 1'b0, iena = 1'b0;
    logic [DW-1:0] in_re = '0, in_im = '0;
    logic          ordy, osop, oval, oeop, ounderrun;
    logic [DW-1:0] out_re, out_im;
    logic [6:0]    count_frame;

    interlayer_addcp #(.DATA_W(DW), .N_FFT(NF), .N_CP(NC)) dut (
        .clk(clk), .rst(rst), .isop(isop), .ival(ival),
        .in_real_data(in_re), .in_imag_data(in_im), .ordy(ordy),
        .iena(iena), .osop(osop), .oval(oval), .oeop(oeop),
        .out_real_data(out_re), .out_imag_data(out_im),
        .count_frame(count_frame), .ounderrun(ounderrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*DW-1:0] d;
        bit              sop;
        bit              eop;
    } exp_t;

    exp_t            sb[$];
    logic [2*DW-1:0] wbuf [NF];
    logic [2*DW-1:0] symq[$];
    int              widx, nfull, remaining, mon_frames;
    bit              exp_oval, exp_urun, m_acc;
    int              n_cmp = 0, n_err = 0;

    function automatic void model_reset();
        sb.delete();
        symq.delete();
        widx = 0; nfull = 0; remaining = 0; mon_frames = 0;
        exp_oval = 0; exp_urun = 0; m_acc = 0;
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: symbols are collected into a FIFO; a request either
    // continues the current LEN-sample output, starts a new one, or underruns.
    always @(posedge clk) begin : model
        bit acc, done, freed, issue, urun;
        if (!rst) begin
            acc = ival && (nfull < 2);
            done = 0; freed = 0; issue = 0; urun = 0;
            if (acc) begin
                if (isop) begin
                    wbuf[0] = {in_re, in_im};
                    widx = 1;
                end else if (widx != 0) begin
                    wbuf[widx] = {in_re, in_im};
                    widx++;
                    if (widx == NF) begin
                        for (int i = 0; i < NF; i++) symq.push_back(wbuf[i]);
                        widx = 0;
                        done = 1;
                    end
                end
            end
            if (iena) begin
                if (remaining > 0) begin
                    issue = 1;
                    remaining--;
                    if (remaining == 0) freed = 1;
                end else if (nfull > 0) begin
                    issue = 1;
                    remaining = LEN - 1;
                    for (int i = 0; i < LEN; i++) begin
                        exp_t e;
                        e.d   = (i < NC) ? symq[NF - NC + i] : symq[i - NC];
                        e.sop = (i == 0);
                        e.eop = (i == LEN - 1);
                        sb.push_back(e);
                    end
                    repeat (NF) void'(symq.pop_front());
                end else begin
                    urun = 1;
                end
            end
            nfull = nfull + int'(done) - int'(freed);
            m_acc = acc; exp_oval = issue; exp_urun = urun;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            chk("ordy", ordy, (nfull < 2));
            chk("ounderrun", ounderrun, exp_urun);
            chk("oval", oval, exp_oval);
            if (oval) begin
                if (sb.size() == 0) begin
                    chk("unexpected_oval", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data", {out_re, out_im}, e.d);
                    chk("osop", osop, e.sop);
                    chk("oeop", oeop, e.eop);
                    if (e.eop) begin
                        mon_frames++;
                        chk("count_frame", count_frame, mon_frames % 128);
                    end
                end
            end else begin
                chk("idle_flags", {osop, oeop}, 0);
            end
        end
    end

    task automatic send(input bit sop, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input int idle_max);
        int budget;
        repeat ($urandom_range(idle_max, 0)) @(negedge clk);
        isop = sop; in_re = re; in_im = im; ival = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!m_acc && budget < 5000);
        if (!m_acc) chk("send_timeout", 1, 0);
        ival = 1'b0; isop = 1'b0;
    endtask

    task automatic send_rand_sym(input int idle_max);
        for (int k = 0; k < NF; k++)
            send(k == 0, DW'($urandom), DW'($urandom), idle_max);
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((sb.size() != 0 || remaining != 0 || nfull != 0) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20000) chk("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_oval", oval, 0);
        chk("rst_ordy", ordy, 1);
        chk("rst_count", count_frame, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin : stim
        bit wdone;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_ordy", ordy, 1);
        chk("reset_oval", {oval, osop, oeop, ounderrun}, 0);
        chk("reset_data", {out_re, out_im}, 0);
        chk("reset_count", count_frame, 0);
        #2 rst = 1'b0;

        // Single symbol, continuous requests: I = k, Q = -k
        iena = 1'b1;
        for (int k = 0; k < NF; k++) send(k == 0, DW'(k), DW'(-k), 0);
        wait_drain();
        chk("single_count", count_frame, 1);

        // Backpressure: three symbols with the reader held off
        iena = 1'b0;
        fork
            begin
                for (int s = 0; s < 3; s++) send_rand_sym(0);
            end
            begin
                repeat (3 * NF) @(negedge clk);
                iena = 1'b1;
            end
        join
        wait_drain();
        chk("bp_count", count_frame, 4);

        // Paced output: request strobe toggles every cycle
        iena = 1'b0;
        wdone = 0;
        fork
            begin
                send_rand_sym(2);
                send_rand_sym(2);
                wdone = 1;
            end
            begin
                int budget = 0;
                while ((!wdone || sb.size() != 0 || remaining != 0 || nfull != 0)
                       && budget < 20000) begin
                    iena = ~iena;
                    @(negedge clk);
                    budget++;
                end
                if (budget >= 20000) chk("paced_timeout", 1, 0);
            end
        join
        iena = 1'b0;
        @(negedge clk);
        chk("paced_count", count_frame, 6);

        // Underrun, dropped orphan sample, then a restarted symbol
        iena = 1'b1;
        repeat (8) @(negedge clk);
        send(1'b0, 12'h7, 12'h7, 0);
        for (int k = 0; k < 30; k++) send(k == 0, DW'(k), DW'(k), 0);
        for (int k = 0; k < NF; k++) send(k == 0, DW'(2000 + k), DW'(k * 3), 0);
        wait_drain();
        chk("restart_count", count_frame, 7);

        // Counter wrap after reset
        do_reset();
        iena = 1'b1;
        for (int s = 0; s < 130; s++) send_rand_sym(1);
        wait_drain();
        chk("wrap_count", count_frame, 2);

        // Reset mid-output with a symbol partly written
        iena = 1'b0;
        send_rand_sym(0);
        iena = 1'b1;
        for (int k = 0; k < 37; k++) send(k == 0, DW'($urandom), DW'($urandom), 0);
        do_reset();
        for (int k = 0; k < NF; k++) send(k == 0, DW'(k), DW'(~k), 0);
        wait_drain();
        chk("post_reset_count", count_frame, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
